serial_seq_gen: RTL and testbench
=================================

// Module: serial_seq_gen
// PURPOSE
//  Serial bit-pattern transmitter. Accepts a pattern word (bits, length, repeat count)
//  over a valid/ready load port and shifts it out MSB-first, one bit per clock, on x.
//  It sits upstream of the serial sequence detectors and drives their x input.
//  Optional repeats are separated by an idle gap of GAP cycles.
// PARAMETERS
//  W    8  max pattern width in bits
//  RW   4  width of repeat-count field
//  GAP  2  idle cycles between repetitions (0 = back-to-back, no idle cycles)
//  LW   $clog2(W)+1 (localparam)  width of length field
// PORTS
//  clk         in   1   rising-edge clock
//  reset_n     in   1   asynchronous reset, active-low
//  load_valid  in   1   load request
//  load_ready  out  1   load is accepted when load_valid && load_ready
//  load_pat    in   W   pattern; bits [load_len-1:0] are used, sent from bit load_len-1 down to bit 0
//  load_len    in   LW  pattern length, 1..W; 0 or >W is treated as W
//  load_rep    in   RW  extra repetitions (0 = send once)
//  abort       in   1   synchronous abort
//  x           out  1   serial data out (registered)
//  x_valid     out  1   x carries a pattern bit this cycle (registered)
//  busy        out  1   high while in SEND or GAP
//  done        out  1   one-cycle pulse after the last bit of the last repetition (registered)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; x=0, x_valid=0, done=0, busy=0; counters=0.
//    load_ready=1 once reset_n is high.
//  - load_ready = (state==IDLE) && !abort. Combinational from state and abort only;
//    load_ready never depends on load_valid.
//  - Accept at edge k: pat, len and rep are latched; bit index is set to len-1; state=SEND.
//    The first bit is on x, with x_valid=1, in cycle k+1. Latency is one cycle.
//  - SEND: each cycle x=pat[idx], x_valid=1, idx decrements.
//    After bit 0:
//      rep_cnt>0 and GAP>0 -> GAP state, rep_cnt decrements;
//      rep_cnt>0 and GAP=0 -> stay in SEND with idx=len-1, rep_cnt decrements;
//      rep_cnt=0           -> IDLE, with done=1 in the first IDLE cycle.
//  - GAP: x=0, x_valid=0 for exactly GAP cycles, then SEND with idx=len-1.
//  - IDLE: x=0, x_valid=0. done is high only in the cycle after the final bit.
//  - Back-to-back loads: a load accepted in the done cycle is legal. Its first bit
//    follows on the next cycle, so the gap between patterns is exactly one cycle.
//  - Inputs load_pat, load_len and load_rep are ignored outside the accept cycle.
//    Changing them mid-send has no effect.
//  - abort=1 in SEND or GAP: next cycle is IDLE with x=0, x_valid=0, done=0.
//    A partial pattern is truncated and no done pulse is issued.
//  - abort and load_valid together in IDLE: abort wins and nothing is accepted.
//  - reset_n low mid-send: outputs clear immediately (async), with no done pulse.
//  - busy = (state!=IDLE).
//  - len=1: one bit per repetition. rep=2^RW-1: 2^RW repetitions total.
//  - All counters are unsigned. idx is LW bits wide and never wraps below 0.
// STRUCTURE
//  - serial_seq_gen_pkg: state encoding (IDLE=2'd0, SEND=2'd1, GAP=2'd2) and a
//    len_norm() function that maps 0 or >W to W.
//  - One sub-module, seq_down_counter: loadable down-counter with a terminal-count flag.
//    It is instantiated twice: once for the bit index and once for the gap count.
//    rep_cnt is a plain register in the top.
//  - Single registered FSM. The next-state block is fully combinational with defaults,
//    so no latches are inferred.
// TESTING
//  1. Reset mid-stream: reset_n=0 -> x=0, x_valid=0, busy=0, done=0 with no clock.
//     After release, load_ready=1.
//  2. pat=8'b0000_1001, len=4, rep=0 -> x=1,0,0,1 with x_valid=1 in cycles 1-4.
//     done=1 in cycle 5 only.
//  3. pat=1011, len=4, rep=1, GAP=2 -> 1,0,1,1, then 2 idle cycles, then 1,0,1,1.
//     Single done pulse at the end. busy=1 for 10 cycles.
//  4. GAP=0, pat=10, len=2, rep=2 -> 1,0,1,0,1,0 with x_valid held high for 6 cycles.
//  5. abort in the 3rd SEND cycle -> x_valid=0 the next cycle, no done,
//     and load_ready=1 again.
//  6. load_len=0, pat=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1.
//     A new load held in the done cycle -> its first bit follows on the next cycle.

Source files
------------

// File: rtl/serial_seq_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
//   state_e  : FSM state encoding
//   len_norm : maps a requested length of 0 or >w onto w
package serial_seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Out-of-range lengths fall back to the full pattern width.
  function automatic int unsigned len_norm(input int unsigned len, input int unsigned w);
    return ((len == 0) || (len > w)) ? w : len;
  endfunction

endpackage

// File: rtl/serial_seq_gen_if.sv
// Load port of the serial pattern transmitter.
//   load_valid : load request (master -> slave)
//   load_ready : slave can accept this cycle (slave -> master)
//   load_pat   : pattern bits, MSB of the used field sent first
//   load_len   : pattern length, 1..W (0 or >W means W)
//   load_rep   : extra repetitions (0 = send once)
interface serial_seq_gen_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 4
);
  import serial_seq_gen_pkg::*;

  localparam int unsigned LW = $clog2(W) + 1;

  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_pat;
  logic [LW-1:0] load_len;
  logic [RW-1:0] load_rep;

  modport master (
    output load_valid,
    output load_pat,
    output load_len,
    output load_rep,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_pat,
    input  load_len,
    input  load_rep,
    output load_ready
  );

endinterface

// File: rtl/serial_seq_gen_counter.sv
// Loadable down-counter that saturates at zero, with a terminal-count flag.
//   clk, reset_n : clock, async active-low reset
//   load         : load load_val (has priority over dec)
//   dec          : decrement by one, holding at zero
//   cnt          : current count (registered)
//   tc_c         : cnt == 0 (combinational)
module seq_down_counter
  import serial_seq_gen_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          tc_c
);

  // Count register; never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/serial_seq_gen.sv
// Serial bit-pattern transmitter: latches a pattern from the load port and
// shifts it out MSB-first on x, optionally repeating with GAP idle cycles between.
//   clk, reset_n : clock, async active-low reset
//   load_if      : load port (valid/ready, pattern, length, repeat count)
//   abort        : synchronous abort of any send in progress
//   x, x_valid   : serial data and its qualifier (registered)
//   busy         : sending or in an inter-repetition gap (registered)
//   done         : one-cycle pulse after the final bit (registered)
module serial_seq_gen
  import serial_seq_gen_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned RW  = 4,
  parameter int unsigned GAP = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  serial_seq_gen_if.slave   load_if,
  input  logic              abort,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LW = $clog2(W) + 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_e        state_q, state_d;
  logic [W-1:0]  pat_q;
  logic [LW-1:0] len_q;
  logic [RW-1:0] rep_q;

  logic          accept_c;
  logic [LW-1:0] len_in;

  logic          idx_load, idx_dec, idx_tc;
  logic [LW-1:0] idx_load_val, idx_cnt;
  logic          gap_load, gap_dec, gap_tc;
  logic [GW-1:0] unused_gap_cnt;

  logic          rep_dec;
  logic          x_d, xv_d, done_d;
  logic [W-1:0]  sel_pat, sel_bits;
  logic [LW-1:0] sel_idx;

  assign load_if.load_ready = (state_q == ST_IDLE) && !abort;
  assign accept_c           = load_if.load_valid && load_if.load_ready;
  assign len_in             = LW'(len_norm(32'(load_if.load_len), W));

  // Index of the bit currently on x.
  seq_down_counter #(.CW(LW)) u_idx_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (idx_load),
    .dec      (idx_dec),
    .load_val (idx_load_val),
    .cnt      (idx_cnt),
    .tc_c     (idx_tc)
  );

  // Remaining idle cycles in the current gap.
  seq_down_counter #(.CW(GW)) u_gap_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (gap_load),
    .dec      (gap_dec),
    .load_val (GAP_LOAD),
    .cnt      (unused_gap_cnt),
    .tc_c     (gap_tc)
  );

  // Next state and next-cycle output values; x is chosen from the bit that
  // will be current after the edge so that it can be registered.
  always_comb begin
    state_d      = state_q;
    idx_load     = 1'b0;
    idx_dec      = 1'b0;
    idx_load_val = len_q - LW'(1);
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    rep_dec      = 1'b0;
    xv_d         = 1'b0;
    done_d       = 1'b0;
    sel_pat      = pat_q;
    sel_idx      = idx_cnt;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d      = ST_SEND;
          idx_load     = 1'b1;
          idx_load_val = len_in - LW'(1);
          sel_pat      = load_if.load_pat;
          sel_idx      = len_in - LW'(1);
          xv_d         = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!idx_tc) begin
          idx_dec = 1'b1;
          sel_idx = idx_cnt - LW'(1);
          xv_d    = 1'b1;
        end else if (rep_q != '0) begin
          rep_dec = 1'b1;
          if (GAP > 0) begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end else begin
            idx_load = 1'b1;
            sel_idx  = len_q - LW'(1);
            xv_d     = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (gap_tc) begin
          state_d  = ST_SEND;
          idx_load = 1'b1;
          sel_idx  = len_q - LW'(1);
          xv_d     = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sel_bits = sel_pat >> sel_idx;
    x_d      = xv_d & sel_bits[0];
  end

  // State, latched load fields and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        pat_q <= load_if.load_pat;
        len_q <= len_in;
        rep_q <= load_if.load_rep;
      end else if (rep_dec) begin
        rep_q <= rep_q - RW'(1);
      end
      x       <= x_d;
      x_valid <= xv_d;
      busy    <= (state_d != ST_IDLE);
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_seq_gen.sv
// Self-checking bench for serial_seq_gen: two instances (GAP=2 and GAP=0),
// directed cases plus randomized loads checked against a stream model.
module tb_serial_seq_gen;

  typedef struct packed {
    logic xv;
    logic x;
    logic busy;
    logic done;
  } obs_t;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic       valid_a, valid_b;
  logic [7:0] ld_pat;
  logic [3:0] ld_len;
  logic [3:0] ld_rep;

  logic x_a, xv_a, busy_a, done_a;
  logic x_b, xv_b, busy_b, done_b;

  int checks;
  int errors;

  serial_seq_gen_if #(.W(8), .RW(4)) ifa ();
  serial_seq_gen_if #(.W(8), .RW(4)) ifb ();

  assign ifa.load_valid = valid_a;
  assign ifa.load_pat   = ld_pat;
  assign ifa.load_len   = ld_len;
  assign ifa.load_rep   = ld_rep;
  assign ifb.load_valid = valid_b;
  assign ifb.load_pat   = ld_pat;
  assign ifb.load_len   = ld_len;
  assign ifb.load_rep   = ld_rep;

  serial_seq_gen #(.W(8), .RW(4), .GAP(2)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .load_if (ifa),
    .abort   (abort),
    .x       (x_a),
    .x_valid (xv_a),
    .busy    (busy_a),
    .done    (done_a)
  );

  serial_seq_gen #(.W(8), .RW(4), .GAP(0)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .load_if (ifb),
    .abort   (abort),
    .x       (x_b),
    .x_valid (xv_b),
    .busy    (busy_b),
    .done    (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic xv, input logic xb, input logic bz, input logic dn);
    obs_t o;
    o.xv   = xv;
    o.x    = xb;
    o.busy = bz;
    o.done = dn;
    return o;
  endfunction

  function automatic int norm_len(input logic [3:0] len);
    return ((len == 4'd0) || (len > 4'd8)) ? 8 : int'(len);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  // Compare one cycle of the selected instance against the expected outputs.
  task automatic cyc(input bit sel, input obs_t e, input string tag);
    chk({tag, "_xv"},    sel ? xv_b   : xv_a,   e.xv);
    chk({tag, "_x"},     sel ? x_b    : x_a,    e.x);
    chk({tag, "_busy"},  sel ? busy_b : busy_a, e.busy);
    chk({tag, "_done"},  sel ? done_b : done_a, e.done);
    chk({tag, "_ready"}, sel ? ifb.load_ready : ifa.load_ready, !e.busy);
  endtask

  // Load one pattern and follow its whole output stream. Entered and left at
  // a negative clock edge; abort_at (1-based stream cycle, 0 = none) aborts.
  task automatic run(input bit sel, input logic [7:0] pat, input logic [3:0] len,
                     input logic [3:0] rep, input int abort_at, input bit tail,
                     input string name);
    obs_t q[$];
    obs_t e;
    int   gap;
    int   nl;
    int   n;
    gap = sel ? 0 : 2;
    nl  = norm_len(len);
    for (int r = 0; r <= int'(rep); r++) begin
      for (int b = nl - 1; b >= 0; b--) q.push_back(mk(1'b1, pat[b], 1'b1, 1'b0));
      if (r < int'(rep))
        for (int g = 0; g < gap; g++) q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    end
    q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    if (tail) q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));

    ld_pat = pat;
    ld_len = len;
    ld_rep = rep;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    #1 chk({name, "_ready_pre"}, sel ? ifb.load_ready : ifa.load_ready, 1'b1);
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
    n = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      n++;
      cyc(sel, e, $sformatf("%s_c%0d", name, n));
      ld_pat = 8'($urandom);
      ld_len = 4'($urandom);
      ld_rep = 4'($urandom);
      if (n == abort_at) begin
        abort = 1'b1;
        #1 chk({name, "_ready_abort"}, sel ? ifb.load_ready : ifa.load_ready, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        #1 cyc(sel, mk(1'b0, 1'b0, 1'b0, 1'b0), {name, "_post_abort"});
        @(negedge clk);
        cyc(sel, mk(1'b0, 1'b0, 1'b0, 1'b0), {name, "_post_abort2"});
        return;
      end
      if (q.size() > 0) @(negedge clk);
    end
  endtask

  initial begin
    int   sel_r;
    int   rep_r;
    int   gap_r;
    int   ab;
    logic [3:0] len_r;
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    abort   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    ld_pat  = '0;
    ld_len  = '0;
    ld_rep  = '0;

    // Outputs are clear during reset before any clock edge.
    #2;
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0), "reset_a");
    chk("reset_b_xv", xv_b, 1'b0);
    #6 reset_n = 1'b1;
    #1 chk("reset_ready", ifa.load_ready, 1'b1);
    @(negedge clk);

    run(0, 8'b0000_1001, 4'd4, 4'd0, 0, 1, "t2_1001");
    run(0, 8'b0000_1011, 4'd4, 4'd1, 0, 1, "t3_gap2");
    run(1, 8'b0000_0010, 4'd2, 4'd2, 0, 1, "t4_gap0");
    run(0, 8'hC6, 4'd8, 4'd0, 3, 1, "t5_abort");
    run(0, 8'h5A, 4'd3, 4'd2, 4, 1, "abort_in_gap");
    run(0, 8'hA5, 4'd0, 4'd0, 0, 0, "t6_len0");
    run(0, 8'h3C, 4'd5, 4'd1, 0, 1, "t6_b2b");
    run(1, 8'h96, 4'd12, 4'd0, 0, 0, "len_over_b");
    run(1, 8'h01, 4'd1, 4'd1, 0, 1, "b2b_b");
    run(0, 8'h01, 4'd1, 4'd15, 0, 1, "len1_rep15");

    // Abort together with a load request in IDLE: nothing is accepted.
    abort   = 1'b1;
    valid_a = 1'b1;
    ld_pat  = 8'hFF;
    ld_len  = 4'd8;
    ld_rep  = 4'd0;
    #1 chk("abort_load_ready", ifa.load_ready, 1'b0);
    @(negedge clk);
    abort   = 1'b0;
    valid_a = 1'b0;
    #1 cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0), "abort_load");
    @(negedge clk);
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0), "abort_load2");

    // Reset in the middle of a send clears outputs without a clock edge.
    ld_pat  = 8'hFF;
    ld_len  = 4'd8;
    ld_rep  = 4'd3;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    @(negedge clk);
    chk("midrst_sending", xv_a, 1'b1);
    #1 reset_n = 1'b0;
    #1 cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0), "midrst");
    #1 reset_n = 1'b1;
    #1 chk("midrst_ready", ifa.load_ready, 1'b1);
    @(negedge clk);
    cyc(0, mk(1'b0, 1'b0, 1'b0, 1'b0), "midrst_after");

    // Randomized loads, occasionally aborted.
    for (int i = 0; i < 24; i++) begin
      sel_r = int'($urandom_range(0, 1));
      len_r = 4'($urandom_range(0, 15));
      rep_r = int'($urandom_range(0, 3));
      gap_r = (sel_r != 0) ? 0 : 2;
      ab    = 0;
      if ($urandom_range(0, 3) == 0)
        ab = int'($urandom_range(1, norm_len(len_r) * (rep_r + 1) + gap_r * rep_r));
      run(sel_r[0], 8'($urandom), len_r, 4'(rep_r), ab, 1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
